// File: rtl/rs_issue_scheduler_pkg.sv
// Shared types and defaults for the reservation-station issue scheduler.
package rs_issue_scheduler_pkg;

    // Frames per E-node; the top-level FRAMES parameter defaults to this.
    localparam int FRAMES_PER_NODE = 8;

    // ALU occupancy, in cycles, after a long-latency op is accepted.
    localparam int LONG_LAT_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OFFER = 2'd1,
        ST_BUSY  = 2'd2
    } sched_state_e;

endpackage : rs_issue_scheduler_pkg

// File: rtl/rs_issue_scheduler_if.sv
// Issue handshake between the scheduler (master) and the node ALU (slave).
interface rs_issue_scheduler_if #(
    parameter int FRAME_W = 3
);
    logic               issue_valid;
    logic [FRAME_W-1:0] issue_frame;
    logic               issue_long;
    logic               issue_ready;

    modport master (
        output issue_valid,
        output issue_frame,
        output issue_long,
        input  issue_ready
    );

    modport slave (
        input  issue_valid,
        input  issue_frame,
        input  issue_long,
        output issue_ready
    );
endinterface : rs_issue_scheduler_if

// File: rtl/rs_issue_scheduler_rr_frame_picker.sv
// Round-robin frame picker: first set request bit scanning ptr, ptr+1, ... (wrapping).
module rr_frame_picker #(
    parameter int FRAMES  = 8,
    parameter int FRAME_W = $clog2(FRAMES)
) (
    input  logic [FRAMES-1:0]  req,
    input  logic [FRAME_W-1:0] ptr,
    output logic [FRAME_W-1:0] gnt_idx,
    output logic               any
);

    logic [FRAME_W-1:0] scan_idx;
    logic               found;

    // Linear wrap-around scan; FRAMES is a power of two so the index add wraps naturally.
    always_comb begin
        // NOTE: every variable written here gets a default first so no latch is inferred.
        gnt_idx  = '0;
        found    = 1'b0;
        scan_idx = '0;
        for (int i = 0; i < FRAMES; i++) begin
            scan_idx = ptr + FRAME_W'(i);
            if (!found && req[scan_idx]) begin
                gnt_idx = scan_idx;
                found   = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule : rr_frame_picker

// File: rtl/rs_issue_scheduler.sv
// Per-E-node issue scheduler: round-robin pick of fire-ready frames, offered to the ALU.
module rs_issue_scheduler
    import rs_issue_scheduler_pkg::*;
#(
    parameter int FRAMES   = FRAMES_PER_NODE,
    parameter int FRAME_W  = $clog2(FRAMES),
    parameter int LONG_LAT = LONG_LAT_DEF,
    parameter int CNT_W    = $clog2(LONG_LAT + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [FRAMES-1:0]   frame_ready,
    input  logic [FRAMES-1:0]   pred_squash,
    input  logic [FRAMES-1:0]   long_op,
    input  logic [FRAMES-1:0]   active_mask,
    input  logic                flush,
    input  logic [FRAMES-1:0]   flush_mask,
    input  logic                revitalize,
    rs_issue_scheduler_if.master issue_if,
    output logic [FRAMES-1:0]   issued_mask,
    output logic                all_issued,
    output logic                alu_busy
);

    sched_state_e       state_q, state_d;
    logic [FRAMES-1:0]  issued_q, issued_d;
    logic [FRAME_W-1:0] rr_q, rr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               valid_q, valid_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               long_q, long_d;

    logic               accept, accept_eff, offer_flushed, offer_squashed, withdraw;
    logic [FRAMES-1:0]  set_vec, clr_vec, cand;
    logic [FRAME_W-1:0] pick_idx;
    logic               pick_any;

    // Resolve this cycle's accept against flush/revitalize/squash and build next issued state.
    always_comb begin
        accept         = valid_q & issue_if.issue_ready;
        offer_flushed  = valid_q & (revitalize | (flush & flush_mask[frame_q]));
        offer_squashed = valid_q & pred_squash[frame_q] & active_mask[frame_q] & ~revitalize;
        accept_eff     = accept & ~offer_flushed;
        // A squash racing an accept loses: the ALU already took the frame.
        withdraw       = offer_flushed | (offer_squashed & ~accept);

        set_vec = revitalize ? '0 : (pred_squash & active_mask);
        if (accept_eff) begin
            set_vec[frame_q] = 1'b1;
        end
        clr_vec  = revitalize ? '1 : (flush ? flush_mask : '0);
        issued_d = (issued_q | set_vec) & ~clr_vec;

        rr_d = rr_q;
        if (revitalize) begin
            rr_d = '0;
        end else if (accept_eff) begin
            rr_d = frame_q + FRAME_W'(1);
        end

        cand = frame_ready & active_mask & ~issued_d & ~pred_squash;
    end

    rr_frame_picker #(
        .FRAMES  (FRAMES),
        .FRAME_W (FRAME_W)
    ) u_picker (
        .req     (cand),
        .ptr     (rr_d),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    // Next-state and registered-output decisions for IDLE / OFFER / BUSY.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        frame_d = frame_q;
        long_d  = long_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d = ST_OFFER;
                    valid_d = 1'b1;
                    frame_d = pick_idx;
                    long_d  = long_op[pick_idx];
                end
            end
            ST_OFFER: begin
                if (withdraw) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end else if (accept_eff) begin
                    if (long_q) begin
                        state_d = ST_BUSY;
                        valid_d = 1'b0;
                        cnt_d   = CNT_W'(LONG_LAT);
                    end else if (pick_any) begin
                        valid_d = 1'b1;
                        frame_d = pick_idx;
                        long_d  = long_op[pick_idx];
                    end else begin
                        state_d = ST_IDLE;
                        valid_d = 1'b0;
                    end
                end
            end
            ST_BUSY: begin
                valid_d = 1'b0;
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    if (pick_any) begin
                        state_d = ST_OFFER;
                        valid_d = 1'b1;
                        frame_d = pick_idx;
                        long_d  = long_op[pick_idx];
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            issued_q <= '0;
            rr_q     <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            frame_q  <= '0;
            long_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q  <= state_d;
            issued_q <= issued_d;
            rr_q     <= rr_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            frame_q  <= frame_d;
            long_q   <= long_d;
        end
    end

    assign issue_if.issue_valid = valid_q;
    assign issue_if.issue_frame = frame_q;
    assign issue_if.issue_long  = long_q;
    assign issued_mask          = issued_q;
    assign all_issued           = &(issued_q | ~active_mask);
    assign alu_busy             = (state_q == ST_BUSY);

endmodule : rs_issue_scheduler

// File: tb/tb_rs_issue_scheduler.sv
// Directed testbench for rs_issue_scheduler with hand-computed expectations.
module tb_rs_issue_scheduler;

    localparam int FRAMES  = 8;
    localparam int FRAME_W = 3;

    logic              clk;
    logic              rst_n;
    logic [FRAMES-1:0] frame_ready;
    logic [FRAMES-1:0] pred_squash;
    logic [FRAMES-1:0] long_op;
    logic [FRAMES-1:0] active_mask;
    logic              flush;
    logic [FRAMES-1:0] flush_mask;
    logic              revitalize;
    logic [FRAMES-1:0] issued_mask;
    logic              all_issued;
    logic              alu_busy;

    int n_total = 0;
    int n_bad   = 0;

    rs_issue_scheduler_if #(.FRAME_W(FRAME_W)) bus ();

    rs_issue_scheduler #(
        .FRAMES   (FRAMES),
        .FRAME_W  (FRAME_W),
        .LONG_LAT (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_ready (frame_ready),
        .pred_squash (pred_squash),
        .long_op     (long_op),
        .active_mask (active_mask),
        .flush       (flush),
        .flush_mask  (flush_mask),
        .revitalize  (revitalize),
        .issue_if    (bus),
        .issued_mask (issued_mask),
        .all_issued  (all_issued),
        .alu_busy    (alu_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        frame_ready      = '0;
        pred_squash      = '0;
        long_op          = '0;
        active_mask      = '0;
        flush            = 1'b0;
        flush_mask       = '0;
        revitalize       = 1'b0;
        bus.issue_ready  = 1'b0;
        rst_n            = 1'b0;
        #2;
        rst_n            = 1'b1;
    endtask

    initial begin
        // ---- Reset state ----
        reset_dut();
        rst_n = 1'b0;
        #1;
        check("rst_valid", bus.issue_valid, 0);
        check("rst_frame", bus.issue_frame, 0);
        check("rst_long", bus.issue_long, 0);
        check("rst_issued", issued_mask, 0);
        check("rst_busy", alu_busy, 0);
        check("rst_all_issued_empty", all_issued, 1);
        active_mask = 8'h04;
        #1;
        check("rst_all_issued_active", all_issued, 0);
        rst_n = 1'b1;
        tick();

        // ---- Single op on frame 2 ----
        reset_dut();
        active_mask     = 8'h04;
        frame_ready     = 8'h04;
        bus.issue_ready = 1'b1;
        tick();
        check("single_valid", bus.issue_valid, 1);
        check("single_frame", bus.issue_frame, 2);
        check("single_long", bus.issue_long, 0);
        check("single_all_issued_pre", all_issued, 0);
        tick();
        check("single_issued", issued_mask, 8'h04);
        check("single_valid_after", bus.issue_valid, 0);
        check("single_all_issued", all_issued, 1);

        // ---- Round-robin, all frames ready, no bubbles ----
        reset_dut();
        active_mask     = 8'hFF;
        frame_ready     = 8'hFF;
        bus.issue_ready = 1'b1;
        tick();
        for (int i = 0; i < FRAMES; i++) begin
            check($sformatf("rr_valid_%0d", i), bus.issue_valid, 1);
            check($sformatf("rr_frame_%0d", i), bus.issue_frame, i);
            check($sformatf("rr_issued_%0d", i), issued_mask, (32'd1 << i) - 1);
            tick();
        end
        check("rr_valid_end", bus.issue_valid, 0);
        check("rr_issued_end", issued_mask, 8'hFF);
        check("rr_all_issued", all_issued, 1);

        // ---- Long op throttles the ALU for LONG_LAT cycles ----
        reset_dut();
        active_mask     = 8'h03;
        frame_ready     = 8'h03;
        long_op         = 8'h01;
        bus.issue_ready = 1'b1;
        tick();
        check("long_offer_frame", bus.issue_frame, 0);
        check("long_offer_long", bus.issue_long, 1);
        check("long_offer_busy", alu_busy, 0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("long_busy_t%0d", k), alu_busy, 1);
            check($sformatf("long_novalid_t%0d", k), bus.issue_valid, 0);
        end
        check("long_issued_mid", issued_mask, 8'h01);
        tick();
        check("long_busy_t5", alu_busy, 0);
        check("long_valid_t5", bus.issue_valid, 1);
        check("long_frame_t5", bus.issue_frame, 1);
        check("long_long_t5", bus.issue_long, 0);
        tick();
        check("long_issued_end", issued_mask, 8'h03);

        // ---- Backpressure with frame_ready toggling ----
        reset_dut();
        active_mask = 8'h08;
        frame_ready = 8'h08;
        tick();
        check("bp_first_frame", bus.issue_frame, 3);
        for (int k = 0; k < 5; k++) begin
            frame_ready = frame_ready ^ 8'h08;
            tick();
            check($sformatf("bp_valid_%0d", k), bus.issue_valid, 1);
            check($sformatf("bp_frame_%0d", k), bus.issue_frame, 3);
            check($sformatf("bp_issued_%0d", k), issued_mask, 0);
        end
        bus.issue_ready = 1'b1;
        tick();
        check("bp_issued_accept", issued_mask, 8'h08);
        check("bp_valid_accept", bus.issue_valid, 0);
        tick();
        check("bp_issued_once", issued_mask, 8'h08);
        check("bp_valid_once", bus.issue_valid, 0);

        // ---- Flush voids a same-cycle accept of the offered frame ----
        reset_dut();
        active_mask = 8'h60;
        frame_ready = 8'h60;
        tick();
        check("fl_offer_frame", bus.issue_frame, 5);
        flush           = 1'b1;
        flush_mask      = 8'h20;
        bus.issue_ready = 1'b1;
        tick();
        check("fl_withdrawn", bus.issue_valid, 0);
        check("fl_issued", issued_mask, 0);
        check("fl_not_busy", alu_busy, 0);
        flush           = 1'b0;
        flush_mask      = '0;
        bus.issue_ready = 1'b0;
        tick();
        check("fl_reoffer_valid", bus.issue_valid, 1);
        check("fl_reoffer_frame", bus.issue_frame, 5);
        bus.issue_ready = 1'b1;
        tick();
        check("fl_next_frame", bus.issue_frame, 6);
        check("fl_issued_5", issued_mask, 8'h20);
        tick();
        check("fl_issued_end", issued_mask, 8'h60);

        // ---- Squash of the offered frame withdraws it ----
        reset_dut();
        active_mask = 8'h03;
        frame_ready = 8'h03;
        tick();
        check("sqo_frame", bus.issue_frame, 0);
        pred_squash = 8'h01;
        tick();
        check("sqo_withdrawn", bus.issue_valid, 0);
        check("sqo_issued", issued_mask, 8'h01);
        pred_squash = 8'h00;
        tick();
        check("sqo_next_valid", bus.issue_valid, 1);
        check("sqo_next_frame", bus.issue_frame, 1);

        // ---- Squash then revitalize ----
        reset_dut();
        active_mask     = 8'h13;
        frame_ready     = 8'h02;
        bus.issue_ready = 1'b1;
        tick();
        check("rv_first_frame", bus.issue_frame, 1);
        tick();
        check("rv_issued_1", issued_mask, 8'h02);
        frame_ready = 8'h00;
        pred_squash = 8'h10;
        tick();
        check("rv_squash_issued", issued_mask, 8'h12);
        check("rv_squash_novalid", bus.issue_valid, 0);
        pred_squash = 8'h00;
        revitalize  = 1'b1;
        tick();
        check("rv_cleared", issued_mask, 0);
        revitalize  = 1'b0;
        frame_ready = 8'h13;
        tick();
        check("rv_ptr_reset_frame", bus.issue_frame, 0);
        tick();
        check("rv_second_frame", bus.issue_frame, 1);
        tick();
        check("rv_frame4_valid", bus.issue_valid, 1);
        check("rv_frame4", bus.issue_frame, 4);
        tick();
        check("rv_issued_end", issued_mask, 8'h13);
        check("rv_all_issued", all_issued, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_rs_issue_scheduler

// File: doc/rs_issue_scheduler.md
Name: rs_issue_scheduler

Overview:
- Per-E-node issue scheduler that sits between one reservation station's FRAMES entries and the node ALU.
- Each cycle it picks one fire-ready, not-yet-issued frame, using round-robin priority, and offers it to the ALU over a valid/ready handshake.
- Tracks issued/nullified frames per block and throttles issue while a non-pipelined long-latency op occupies the ALU.
- Honours block flush (partial, by mask) and S-morph revitalization.

Parameters:
- FRAMES, 8, frames per node; power of two, >= 2.
- FRAME_W, $clog2(FRAMES), frame index width.
- LONG_LAT, 4, ALU busy cycles after a long-op accept; >= 1.
- CNT_W, $clog2(LONG_LAT+1), busy counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- frame_ready  in  FRAMES  per-frame operands valid and predicate satisfied.
- pred_squash  in  FRAMES  per-frame predicate resolved false; nullify the frame without issue.
- long_op  in  FRAMES  frame holds a multi-cycle op (div/mul class).
- active_mask  in  FRAMES  frames mapped by the current block.
- flush  in  1  block abort, qualified by flush_mask.
- flush_mask  in  FRAMES  frames to clear on flush.
- revitalize  in  1  S-morph re-execute: clear all issued state.
- issue_ready  in  1  ALU accepts the offer.
- issue_valid  out  1  offer valid.
- issue_frame  out  FRAME_W  offered frame index.
- issue_long  out  1  offered frame is a long op.
- issued_mask  out  FRAMES  frames issued or nullified.
- all_issued  out  1  level: (issued_mask | ~active_mask) all ones.
- alu_busy  out  1  state == BUSY.

Behaviour:
- Reset:
  - state=IDLE, issued_mask=0, rr_ptr=0, busy_cnt=0.
  - issue_valid=0, issue_frame=0, issue_long=0.
  - all_issued=1 iff active_mask is all zero (combinational).
- Candidate set: cand = frame_ready & active_mask & ~issued_mask & ~pred_squash.
- Pick: first set bit of cand scanning rr_ptr, rr_ptr+1, ... modulo FRAMES (wraps).
- All outputs are registered except all_issued.
- States: IDLE, OFFER, BUSY.
- IDLE:
  - if cand != 0: go to OFFER next cycle, with issue_valid=1, issue_frame=pick, issue_long=long_op[pick].
  - Latency from frame_ready rising to issue_valid is 1 cycle.
- OFFER:
  - The offer is held stable until issue_ready, even if frame_ready[issue_frame] drops.
  - On accept (issue_valid & issue_ready):
    - issued_mask[issue_frame]<=1 and rr_ptr<=issue_frame+1 (mod FRAMES).
    - If issue_long: go to BUSY, busy_cnt<=LONG_LAT, issue_valid<=0.
    - Otherwise: recompute cand excluding the accepted frame, with the pick scan starting at issue_frame+1 (mod FRAMES), i.e. the updated rr_ptr value. If nonzero, stay in OFFER with the new pick (back-to-back, no bubble); else go to IDLE.
- BUSY:
  - busy_cnt decrements each cycle.
  - When busy_cnt==1, behave as IDLE for the next-state decision.
  - Net effect: long accept at cycle t means the earliest next issue_valid is at t+LONG_LAT+1.
- Squash:
  - pred_squash[f] sets issued_mask[f] next cycle, for active frames only.
  - If f is currently offered, the offer is withdrawn (issue_valid=0 next cycle) and the next pick follows.
  - A same-cycle accept of f still counts; the frame is marked issued once.
- Flush:
  - Clears issued_mask bits in flush_mask.
  - If the offered frame is in flush_mask, the offer is withdrawn and an accept in the flush cycle is void: no issued bit is set, rr_ptr is unchanged, and no BUSY is entered.
  - BUSY continues counting (the ALU is physically occupied).
- Revitalize:
  - issued_mask<=0 and rr_ptr<=0.
  - Any offer is withdrawn, as with a full flush.
  - BUSY is unaffected.
  - Same-cycle pred_squash is ignored.
- Priority per bit: revitalize > flush > squash > accept.
- Pick combinational path is O(FRAMES); no multi-cycle paths.

Decomposition:
- Shared package: the state enum (IDLE/OFFER/BUSY), LONG_LAT default constant, and FRAMES_PER_NODE reuse.
- One sub-module, rr_frame_picker: combinational rotate + priority encode. Inputs are req[FRAMES] and ptr; outputs are gnt_idx and any.

Test Plan:
- Single op: frame_ready=8'b0000_0100 at cycle 1, issue_ready=1 → issue_valid at cycle 2 with frame=2; issued_mask=0x04 at cycle 3; all_issued=1 with active_mask=0x04.
- Round-robin: ready=0xFF held, issue_ready=1 → frames issued 0,1,...,7 on consecutive cycles, no bubbles; after frame 7, issue_valid=0.
- Long op: ready=0x03, long_op=0x01, LONG_LAT=4 → frame 0 accepted at t; alu_busy high t+1..t+4; frame 1 offered at t+5.
- Backpressure: issue_ready=0 for 5 cycles while frame_ready[3] toggles → issue_frame stays 3 and issue_valid stays 1; on accept, issued_mask bit 3 is set exactly once.
- Flush vs accept: frame 5 offered, flush=1 with flush_mask=0x20 and issue_ready=1 in the same cycle → issued_mask[5]=0, offer dropped, frame 5 re-offered once ready.
- Squash + revitalize: pred_squash=0x10 → issued_mask=0x10 with no issue; then revitalize → issued_mask=0, rr_ptr=0; frame 4 is issuable again.
